// File: rtl/mips_fetch_queue_if.sv
// Fetch-queue bundle: branch/halt control, instruction-memory req/ack port and the
// IR/NPC valid/ready port towards IF.
//   redirect_valid/redirect_pc  taken branch/jump and its word target
//   halt                        HLT decoded; stops new fetches until reset
//   mem_req/mem_addr            word read request, held until mem_ack
//   mem_ack/mem_rdata           read completion and instruction word
//   out_valid/out_ir/out_npc    FIFO head (instruction and its PC+1)
//   out_ready                   IF consumes the head this cycle
// master: the fetch queue itself. slave: the surrounding pipeline and memory.
interface mips_fetch_queue_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              halt;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              out_valid;
  logic [31:0]       out_ir;
  logic [31:0]       out_npc;
  logic              out_ready;

  modport master (
    input  redirect_valid, redirect_pc, halt, mem_ack, mem_rdata, out_ready,
    output mem_req, mem_addr, out_valid, out_ir, out_npc
  );

  modport slave (
    output redirect_valid, redirect_pc, halt, mem_ack, mem_rdata, out_ready,
    input  mem_req, mem_addr, out_valid, out_ir, out_npc
  );
endinterface

// File: rtl/mips_fetch_queue.sv
// Instruction prefetch queue in front of the IF/ID register.
// Issues one word read at a time to instruction memory, buffers returned words with their
// PC+1 in a DEPTH-entry FIFO and presents the head to IF over valid/ready. A redirect
// flushes the FIFO and refetches from the new PC; halt stops new fetches until reset.
//   clk1  pipeline clock, all state on posedge
//   rst   synchronous active-high reset
//   bus   mips_fetch_queue_if.master (control, memory port, IF port)
module mips_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                clk1,
  input  logic                rst,
  mips_fetch_queue_if.master  bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              halted_q, halted_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]       ir_q  [DEPTH];
  logic [31:0]       npc_q [DEPTH];
  logic              push, pop;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    halted_d   = halted_q | bus.halt;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    push       = 1'b0;
    // A redirect cancels any pop in the same cycle.
    pop        = (count_q != '0) && bus.out_ready && !bus.redirect_valid;

    unique case (state_q)
      StIdle: begin
        // Nothing is outstanding here, so count < DEPTH guarantees room for the ack.
        if (!halted_d && !bus.redirect_valid && (count_q < DepthC)) begin
          addr_d  = fetch_pc_q[ADDR_W-1:0];
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.mem_ack) begin
          state_d = StIdle;
          if (!bus.redirect_valid) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd1;
          end
        end else if (bus.redirect_valid) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Stale request: keep it up until memory answers, then drop the data.
        if (bus.mem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      halted_q   <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ir_q[i]  <= '0;
        npc_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        ir_q[wr_ptr_q]  <= bus.mem_rdata;
        npc_q[wr_ptr_q] <= fetch_pc_q + 32'd1;
      end
    end
  end

  assign bus.mem_req   = (state_q != StIdle);
  assign bus.mem_addr  = addr_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_ir    = ir_q[rd_ptr_q];
  assign bus.out_npc   = npc_q[rd_ptr_q];

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: directed scenarios with hand-computed expectations pushed
// into scoreboard queues; a memory model and an output monitor pop and compare.
// Memory word at address a holds 32'hA000_0000 + a.
module tb_mips_fetch_queue;
  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  mips_fetch_queue_if #(.ADDR_W(10)) bus ();

  mips_fetch_queue #(
    .DEPTH    (4),
    .ADDR_W   (10),
    .RESET_PC (32'd0)
  ) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } entry_t;

  entry_t     exp_q[$];
  logic [9:0] addr_q[$];
  int checks = 0;
  int failures = 0;
  int lat = 1;
  int req_count = 0;
  int ack_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic exp_entry(input logic [31:0] ir, input logic [31:0] npc);
    entry_t e;
    e.ir  = ir;
    e.npc = npc;
    exp_q.push_back(e);
  endtask

  // Memory: acks `lat` cycles into each request; checks the address of every new request.
  initial begin
    int cnt;
    bit prev;
    cnt = 0;
    prev = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk1);
      #1;
      if (bus.mem_req) begin
        if (!prev) begin
          req_count++;
          cnt = 0;
          if (addr_q.size() != 0) begin
            logic [9:0] a;
            a = addr_q.pop_front();
            check("mem_addr", 32'(bus.mem_addr), 32'(a));
          end
        end
        cnt++;
        if (cnt >= lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = 32'hA000_0000 + 32'(bus.mem_addr);
          ack_count++;
        end else begin
          bus.mem_ack = 1'b0;
        end
      end else begin
        cnt = 0;
        bus.mem_ack = 1'b0;
      end
      prev = bus.mem_req;
    end
  end

  // Output monitor: every accepted head entry must match the scoreboard front.
  initial begin
    forever begin
      @(negedge clk1);
      #1;
      if (!rst && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop actual ir=0x%08h npc=0x%08h required none",
                   bus.out_ir, bus.out_npc);
        end else begin
          entry_t e;
          e = exp_q.pop_front();
          check("out_ir", bus.out_ir, e.ir);
          check("out_npc", bus.out_npc, e.npc);
        end
      end
    end
  end

  task automatic do_reset(input bit redir, input logic [31:0] pc);
    @(negedge clk1);
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.halt = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk1);
    req_count = 0;
    ack_count = 0;
    rst = 1'b0;
    if (redir) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = pc;
      @(negedge clk1);
      bus.redirect_valid = 1'b0;
    end
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk1);
    bus.out_ready = 1'b0;
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    check({name, "_addrs"}, 32'(addr_q.size()), 32'd0);
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic wait_req(input string name);
    int i;
    for (i = 0; i < 50 && !bus.mem_req; i++) @(negedge clk1);
    check({name, "_req_seen"}, 32'(bus.mem_req), 32'd1);
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.halt = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    do_reset(1'b0, 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_ir", bus.out_ir, 32'd0);
    check("rst_out_npc", bus.out_npc, 32'd0);

    // 1: zero-wait memory, streaming
    lat = 1;
    for (int a = 0; a < 4; a++) addr_q.push_back(10'(a));
    exp_entry(32'hA000_0000, 32'd1);
    exp_entry(32'hA000_0001, 32'd2);
    exp_entry(32'hA000_0002, 32'd3);
    exp_entry(32'hA000_0003, 32'd4);
    bus.out_ready = 1'b1;
    wait_empty("t1");

    // 2: stalled IF fills the FIFO, then drains and fetching resumes at pc=4
    do_reset(1'b0, 32'd0);
    for (int a = 0; a < 4; a++) addr_q.push_back(10'(a));
    repeat (20) @(negedge clk1);
    check("t2_req_count", 32'(req_count), 32'd4);
    check("t2_mem_req", 32'(bus.mem_req), 32'd0);
    check("t2_out_valid", 32'(bus.out_valid), 32'd1);
    check("t2_hold_ir", bus.out_ir, 32'hA000_0000);
    check("t2_hold_npc", bus.out_npc, 32'd1);
    addr_q.push_back(10'd4);
    exp_entry(32'hA000_0000, 32'd1);
    exp_entry(32'hA000_0001, 32'd2);
    exp_entry(32'hA000_0002, 32'd3);
    exp_entry(32'hA000_0003, 32'd4);
    exp_entry(32'hA000_0004, 32'd5);
    bus.out_ready = 1'b1;
    wait_empty("t2");

    // 3: redirect while a 3-cycle request is outstanding
    do_reset(1'b0, 32'd0);
    lat = 3;
    addr_q.push_back(10'h000);
    addr_q.push_back(10'h020);
    addr_q.push_back(10'h021);
    exp_entry(32'hA000_0020, 32'h21);
    exp_entry(32'hA000_0021, 32'h22);
    bus.out_ready = 1'b1;
    wait_req("t3");
    @(negedge clk1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    @(negedge clk1);
    bus.redirect_valid = 1'b0;
    wait_empty("t3");

    // 4: redirect coincident with an ack and a pop, two entries buffered
    do_reset(1'b0, 32'd0);
    lat = 2;
    addr_q.push_back(10'h000);
    addr_q.push_back(10'h001);
    addr_q.push_back(10'h002);
    addr_q.push_back(10'h040);
    addr_q.push_back(10'h041);
    exp_entry(32'hA000_0040, 32'h41);
    exp_entry(32'hA000_0041, 32'h42);
    for (int i = 0; i < 100 && !(bus.mem_ack && ack_count == 3); i++) @(negedge clk1);
    check("t4_third_ack", 32'(ack_count), 32'd3);
    check("t4_two_buffered", 32'(bus.out_valid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    bus.out_ready = 1'b1;
    @(negedge clk1);
    bus.redirect_valid = 1'b0;
    check("t4_flushed", 32'(bus.out_valid), 32'd0);
    wait_empty("t4");

    // 5: halt with a request outstanding, then reset restarts from RESET_PC
    do_reset(1'b0, 32'd0);
    lat = 3;
    addr_q.push_back(10'h000);
    exp_entry(32'hA000_0000, 32'd1);
    bus.out_ready = 1'b1;
    wait_req("t5");
    bus.halt = 1'b1;
    repeat (20) @(negedge clk1);
    check("t5_req_count", 32'(req_count), 32'd1);
    check("t5_mem_req", 32'(bus.mem_req), 32'd0);
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    wait_empty("t5_halt");
    do_reset(1'b0, 32'd0);
    addr_q.push_back(10'h000);
    exp_entry(32'hA000_0000, 32'd1);
    bus.out_ready = 1'b1;
    wait_empty("t5_restart");

    // 6: address wrap at the top of instruction memory, full 32-bit npc
    lat = 1;
    addr_q.push_back(10'h3FF);
    addr_q.push_back(10'h000);
    exp_entry(32'hA000_03FF, 32'h400);
    exp_entry(32'hA000_0000, 32'h401);
    do_reset(1'b1, 32'h3FF);
    bus.out_ready = 1'b1;
    wait_empty("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
